// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a shared-memory multi-cycle RV32I datapath (lw, sw, R/I ALU, beq, jal).
// Optional MEM_WAIT_EN: FETCH, MEMREAD and MEMWRITE stall until mem_ready is high.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic [2:0]         func3,
  input  logic [6:0]         func7,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [2:0]         alu_ctrl,
  output logic               reg_write,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     cur_state, nxt_state;
  logic       mem_go;
  logic       pc_update, branch, ir_wr, mem_wr, reg_wr;
  logic [1:0] alu_op;
  logic       unused_inputs;

`ifdef MEM_WAIT_EN
  assign mem_go        = mem_ready;
  assign unused_inputs = ^{func7[6], func7[4:0]};
`else
  assign mem_go        = 1'b1;
  assign unused_inputs = ^{func7[6], func7[4:0], mem_ready};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_FETCH;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state  = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_wr      = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (cur_state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_go) begin
          ir_wr     = 1'b1;
          pc_update = 1'b1;
          nxt_state = S_DECODE;
        end else begin
          nxt_state = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_R:         nxt_state = S_EXECR;
          OP_I:         nxt_state = S_EXECI;
          OP_BEQ:       nxt_state = S_BEQ;
          OP_JAL:       nxt_state = S_JAL;
          default:      nxt_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        nxt_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src   = 1'b1;
        nxt_state = mem_go ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_wr     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_wr    = 1'b1;
        nxt_state = mem_go ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        nxt_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        nxt_state = S_ALUWB;
      end
      S_ALUWB: reg_wr = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        nxt_state = S_ALUWB;
      end
      default: nxt_state = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Only R-type (op[5]=1) may subtract on func3=000; addi ignores func7.
  always_comb begin
    case (alu_op)
      2'b00: alu_ctrl = 3'b000;
      2'b01: alu_ctrl = 3'b001;
      2'b10: begin
        case (func3)
          3'b000:  alu_ctrl = (op[5] & func7[5]) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl = 3'b101;
          3'b110:  alu_ctrl = 3'b011;
          3'b111:  alu_ctrl = 3'b010;
          default: alu_ctrl = 3'b111;
        endcase
      end
      default: alu_ctrl = 3'b111;
    endcase
  end

  // Strobes are gated by rst_n so nothing commits while reset is held.
  assign pc_write  = rst_n & (pc_update | (branch & alu_zero));
  assign ir_write  = rst_n & ir_wr;
  assign mem_write = rst_n & mem_wr;
  assign reg_write = rst_n & reg_wr;
  assign state     = cur_state;

endmodule
